// File: rtl/uart_fifo_host_pkg.sv
// Shared types and sizes for the host side of the UART FIFO pair.
package uart_fifo_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [1:0] rxcnt_t;

  localparam int RXBUF_DEPTH = 2;

  localparam int STAT_W  = 16;
  localparam int STALL_W = 10;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/uart_fifo_host_if.sv
// FIFO-side and stream-side signals of uart_fifo_host.
// Statistics outputs exist only when UART_FIFO_HOST_STATS_EN is defined.
interface uart_fifo_host_if;
  import uart_fifo_pkg::*;

  logic  RX_FIFO_RDEN;
  logic  RX_FIFO_EMPTY;
  byte_t RX_FIFO_DIN;
  byte_t M_TDATA;
  logic  M_TVALID;
  logic  M_TLAST;
  logic  M_TREADY;
  byte_t S_TDATA;
  logic  S_TVALID;
  logic  S_TREADY;
  logic  TX_FIFO_WREN;
  logic  TX_FIFO_FULL;
  byte_t TX_FIFO_DOUT;

`ifdef UART_FIFO_HOST_STATS_EN
  logic [STAT_W-1:0]  RX_COUNT;
  logic [STAT_W-1:0]  TX_COUNT;
  logic [STALL_W-1:0] TX_STALL;

  // slave is the host block itself, master is whatever surrounds it
  modport slave (
    input  RX_FIFO_EMPTY, RX_FIFO_DIN, M_TREADY, S_TDATA, S_TVALID, TX_FIFO_FULL,
    output RX_FIFO_RDEN, M_TDATA, M_TVALID, M_TLAST, S_TREADY, TX_FIFO_WREN,
           TX_FIFO_DOUT, RX_COUNT, TX_COUNT, TX_STALL
  );
  modport master (
    output RX_FIFO_EMPTY, RX_FIFO_DIN, M_TREADY, S_TDATA, S_TVALID, TX_FIFO_FULL,
    input  RX_FIFO_RDEN, M_TDATA, M_TVALID, M_TLAST, S_TREADY, TX_FIFO_WREN,
           TX_FIFO_DOUT, RX_COUNT, TX_COUNT, TX_STALL
  );
`else
  modport slave (
    input  RX_FIFO_EMPTY, RX_FIFO_DIN, M_TREADY, S_TDATA, S_TVALID, TX_FIFO_FULL,
    output RX_FIFO_RDEN, M_TDATA, M_TVALID, M_TLAST, S_TREADY, TX_FIFO_WREN,
           TX_FIFO_DOUT
  );
  modport master (
    output RX_FIFO_EMPTY, RX_FIFO_DIN, M_TREADY, S_TDATA, S_TVALID, TX_FIFO_FULL,
    input  RX_FIFO_RDEN, M_TDATA, M_TVALID, M_TLAST, S_TREADY, TX_FIFO_WREN,
           TX_FIFO_DOUT
  );
`endif

endinterface

// File: rtl/uart_fifo_host_rxbuf.sv
// Two-entry skid buffer behind the RX FIFO read port, tracking the byte
// still in flight from the FIFO so it is never over-requested.
module uart_fifo_host_rxbuf
  import uart_fifo_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   rx_empty,
  input  byte_t  rx_din,
  input  logic   pop,
  output logic   rden,
  output logic   inflight,
  output rxcnt_t count,
  output byte_t  head
);

  byte_t tail;
  logic  rd_ok;

  assign rd_ok = !rx_empty && ((count + rxcnt_t'(inflight)) < rxcnt_t'(RXBUF_DEPTH));
  assign rden  = rd_ok && !rst;

  // The FIFO presents read data the cycle after rden, so inflight marks the push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_ok;
      case ({inflight, pop})
        2'b10: begin
          if (count == '0) head <= rx_din;
          else             tail <= rx_din;
          count <= count + 1'b1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 1'b1;
        end
        2'b11: begin
          if (count == rxcnt_t'(1)) begin
            head <= rx_din;
          end else begin
            head <= tail;
            tail <= rx_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_host.sv
// Host end of the UART FIFO pair: RX bytes out as a TLAST-framed stream, TX stream into the FIFO.
// Define UART_FIFO_HOST_STATS_EN to add the RX_COUNT/TX_COUNT/TX_STALL counters.
module uart_fifo_host
  import uart_fifo_pkg::*;
#(
  parameter int IDLE_CYCLES = 64,
  parameter int IDLE_BITS   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  uart_fifo_host_if.slave  bus
);

  localparam logic [IDLE_BITS-1:0] IDLE_MAX = IDLE_BITS'(IDLE_CYCLES);

  logic                 pop;
  logic                 rden;
  logic                 inflight;
  rxcnt_t               count;
  byte_t                head;
  logic [IDLE_BITS-1:0] timer;
  logic                 holding;
  logic                 hold_last;
  logic                 idle_done;
  logic                 present_now;
  logic                 last_now;

  uart_fifo_host_rxbuf u_rxbuf (
    .clk      (CLK),
    .rst      (RESET),
    .rx_empty (bus.RX_FIFO_EMPTY),
    .rx_din   (bus.RX_FIFO_DIN),
    .pop      (pop),
    .rden     (rden),
    .inflight (inflight),
    .count    (count),
    .head     (head)
  );

  assign bus.RX_FIFO_RDEN = rden;

  assign idle_done = (count == rxcnt_t'(1)) && !inflight && (timer == IDLE_MAX);

  // With framing on, a lone byte waits for the idle gap so it can carry TLAST
  always_comb begin
    present_now = 1'b0;
    last_now    = 1'b0;
    if (IDLE_CYCLES == 0) begin
      present_now = (count != '0);
    end else begin
      present_now = (count == rxcnt_t'(RXBUF_DEPTH)) || idle_done;
      last_now    = idle_done;
    end
  end

  assign bus.M_TVALID = holding | present_now;
  assign bus.M_TLAST  = holding ? hold_last : last_now;
  assign bus.M_TDATA  = head;
  assign pop          = bus.M_TVALID & bus.M_TREADY;

  // holding/hold_last pin an offered byte and its TLAST until the sink takes it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timer     <= '0;
      holding   <= 1'b0;
      hold_last <= 1'b0;
    end else begin
      holding   <= bus.M_TVALID & !bus.M_TREADY;
      hold_last <= bus.M_TVALID & !bus.M_TREADY & bus.M_TLAST;
      if (!pop && (count == rxcnt_t'(1)) && !inflight && bus.RX_FIFO_EMPTY) begin
        if (timer != IDLE_MAX) timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
    end
  end

  assign bus.S_TREADY     = !bus.TX_FIFO_FULL;
  assign bus.TX_FIFO_WREN = bus.S_TVALID & !bus.TX_FIFO_FULL;
  assign bus.TX_FIFO_DOUT = bus.S_TDATA;

`ifdef UART_FIFO_HOST_STATS_EN
  logic [STAT_W-1:0]  rx_count;
  logic [STAT_W-1:0]  tx_count;
  logic [STALL_W-1:0] tx_stall;

  // Byte counters wrap freely; the stall counter sticks at its maximum
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_count <= '0;
      tx_count <= '0;
      tx_stall <= '0;
    end else begin
      if (pop)              rx_count <= rx_count + 1'b1;
      if (bus.TX_FIFO_WREN) tx_count <= tx_count + 1'b1;
      if (bus.S_TVALID && bus.TX_FIFO_FULL && (tx_stall != STALL_MAX))
        tx_stall <= tx_stall + 1'b1;
    end
  end

  assign bus.RX_COUNT = rx_count;
  assign bus.TX_COUNT = tx_count;
  assign bus.TX_STALL = tx_stall;
`endif

endmodule

// File: tb/tb_uart_fifo_host.sv
// Directed bench for uart_fifo_host: one instance without framing, one with a 4-cycle idle gap.
// Counter checks are included when UART_FIFO_HOST_STATS_EN is defined.
module tb_uart_fifo_host;
  import uart_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_fifo_host_if if0 ();
  uart_fifo_host_if if4 ();

  uart_fifo_host #(.IDLE_CYCLES(0), .IDLE_BITS(8)) dut0 (.CLK(clk), .RESET(rst), .bus(if0.slave));
  uart_fifo_host #(.IDLE_CYCLES(4), .IDLE_BITS(8)) dut4 (.CLK(clk), .RESET(rst), .bus(if4.slave));

  // RX FIFO models: bench writes, read port pops with one cycle of latency
  byte_t mem0 [64];
  byte_t mem4 [64];
  int wr0 = 0, rd0 = 0, wr4 = 0, rd4 = 0;

  assign if0.RX_FIFO_EMPTY = (rd0 == wr0);
  assign if4.RX_FIFO_EMPTY = (rd4 == wr4);

  always @(posedge clk) begin
    if (if0.RX_FIFO_RDEN) begin
      if0.RX_FIFO_DIN <= mem0[rd0 % 64];
      rd0 <= rd0 + 1;
    end
  end

  always @(posedge clk) begin
    if (if4.RX_FIFO_RDEN) begin
      if4.RX_FIFO_DIN <= mem4[rd4 % 64];
      rd4 <= rd4 + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_rx(input int which, input byte_t b);
    if (which == 0) begin
      mem0[wr0 % 64] = b;
      wr0 = wr0 + 1;
    end else begin
      mem4[wr4 % 64] = b;
      wr4 = wr4 + 1;
    end
  endtask

  task automatic applyStimulus(input logic s_valid, input byte_t s_data, input logic full);
    if0.S_TVALID     = s_valid;
    if0.S_TDATA      = s_data;
    if0.TX_FIFO_FULL = full;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected finish earlier");
    $fatal(1, "[TB] time limit reached");
  end

  byte_t got[4];
  int    n_got, first_valid, rden_pulses, tlast_seen;
  logic [16:0] rec3 [2];
  byte_t txrec [8];
  int    n_tx, k;
  logic  full;
  logic  found;
  logic [1:0] exp_tx [7];

  initial begin
    exp_tx = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11};
    rst = 1'b1;
    if0.M_TREADY = 1'b1;
    if4.M_TREADY = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    if4.S_TVALID = 1'b0;
    if4.S_TDATA = 8'h00;
    if4.TX_FIFO_FULL = 1'b0;
    step();
    step();
    checkOutput("reset rx0", 32'({if0.M_TVALID, if0.M_TLAST, if0.RX_FIFO_RDEN, if0.M_TDATA}), 32'h0);
    checkOutput("reset rx4", 32'({if4.M_TVALID, if4.M_TLAST, if4.RX_FIFO_RDEN, if4.M_TDATA}), 32'h0);
`ifdef UART_FIFO_HOST_STATS_EN
    checkOutput("reset counts", 32'({if0.RX_COUNT, if0.TX_COUNT}), 32'h0);
    checkOutput("reset stall", 32'(if0.TX_STALL), 32'h0);
`endif
    rst = 1'b0;
    step();

    // No framing: three bytes stream out in order, never with TLAST
    push_rx(0, 8'h11);
    push_rx(0, 8'h22);
    push_rx(0, 8'h33);
    n_got = 0; first_valid = -1; rden_pulses = 0; tlast_seen = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (if0.RX_FIFO_RDEN) rden_pulses++;
      if (if0.M_TVALID) begin
        if (first_valid < 0) first_valid = i;
        if (if0.M_TLAST) tlast_seen++;
        if (n_got < 4) got[n_got] = if0.M_TDATA;
        n_got++;
      end
      step();
    end
    checkOutput("t1 byte count", 32'(n_got), 32'd3);
    checkOutput("t1 byte0", 32'(got[0]), 32'h11);
    checkOutput("t1 byte1", 32'(got[1]), 32'h22);
    checkOutput("t1 byte2", 32'(got[2]), 32'h33);
    checkOutput("t1 latency", 32'(first_valid), 32'd2);
    checkOutput("t1 rden pulses", 32'(rden_pulses), 32'd3);
    checkOutput("t1 tlast seen", 32'(tlast_seen), 32'd0);

    // Framing: a lone byte is offered with TLAST only after 4 empty cycles
    push_rx(4, 8'hA5);
    for (int i = 0; i < 7; i++) begin
      #1;
      if (i < 6) checkOutput("t2 early", 32'({if4.M_TVALID, if4.M_TLAST}), 32'h0);
      else       checkOutput("t2 tlast", 32'({if4.M_TVALID, if4.M_TLAST, if4.M_TDATA}), 32'h3A5);
      if (i < 6) step();
    end
    if4.M_TREADY = 1'b1;
    step();
    #1;
    checkOutput("t2 popped", 32'(if4.M_TVALID), 32'h0);
    step();

    // Back-to-back pair: first without TLAST at cycle 3, second with TLAST at cycle 8
    push_rx(4, 8'h01);
    push_rx(4, 8'h02);
    n_got = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (if4.M_TVALID) begin
        if (n_got < 2) rec3[n_got] = {i[7:0], if4.M_TLAST, if4.M_TDATA};
        n_got++;
      end
      step();
    end
    checkOutput("t3 byte count", 32'(n_got), 32'd2);
    checkOutput("t3 first", 32'(rec3[0]), 32'({8'd3, 1'b0, 8'h01}));
    checkOutput("t3 second", 32'(rec3[1]), 32'({8'd8, 1'b1, 8'h02}));

    // Offered TLAST byte held under backpressure while the next byte arrives
    if4.M_TREADY = 1'b0;
    push_rx(4, 8'h5A);
    repeat (6) step();
    #1;
    checkOutput("t4 present", 32'({if4.M_TVALID, if4.M_TLAST, if4.M_TDATA}), 32'h35A);
    push_rx(4, 8'h6B);
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      checkOutput("t4 hold", 32'({if4.M_TVALID, if4.M_TLAST, if4.RX_FIFO_RDEN, if4.M_TDATA}),
                  32'({1'b1, 1'b1, 1'b0, 8'h5A}));
    end
    if4.M_TREADY = 1'b1;
    step();
    #1;
    checkOutput("t4 popped", 32'(if4.M_TVALID), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (if4.M_TVALID) found = 1'b1;
    end
    checkOutput("t4 next", 32'({found, if4.M_TLAST, if4.M_TDATA}), 32'({1'b1, 1'b1, 8'h6B}));
    step();

    // TX: FIFO full on cycles 2 and 3 stalls the stream without losing bytes
    k = 0; n_tx = 0;
    for (int j = 0; j < 7; j++) begin
      full = (j == 2) || (j == 3);
      applyStimulus(k < 5, 8'h10 + 8'(k), full);
      #1;
      checkOutput("t5 ready/wren", 32'({if0.S_TREADY, if0.TX_FIFO_WREN}), 32'(exp_tx[j]));
      if (if0.TX_FIFO_WREN && n_tx < 8) begin
        txrec[n_tx] = if0.TX_FIFO_DOUT;
        n_tx++;
      end
      if (!full && k < 5) k++;
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t5 write count", 32'(n_tx), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput("t5 write data", 32'(txrec[i]), 32'h10 + 32'(i));
`ifdef UART_FIFO_HOST_STATS_EN
    checkOutput("stats rx count", 32'(if0.RX_COUNT), 32'd3);
    checkOutput("stats tx count", 32'(if0.TX_COUNT), 32'd5);
    checkOutput("stats tx stall", 32'(if0.TX_STALL), 32'd2);
`endif
    step();

    // Reset with two bytes buffered and a third still in the RX FIFO
    if0.M_TREADY = 1'b0;
    push_rx(0, 8'h77);
    push_rx(0, 8'h88);
    push_rx(0, 8'h99);
    repeat (4) step();
    #1;
    checkOutput("t6 before reset", 32'({if0.M_TVALID, if0.M_TDATA}), 32'h177);
    rst = 1'b1;
    #1;
    checkOutput("t6 in reset", 32'({if0.M_TVALID, if0.M_TLAST, if0.RX_FIFO_RDEN, if0.M_TDATA}), 32'h0);
`ifdef UART_FIFO_HOST_STATS_EN
    checkOutput("t6 reset counts", 32'({if0.RX_COUNT, if0.TX_COUNT}), 32'h0);
`endif
    step();
    rst = 1'b0;
    #1;
    checkOutput("t6 after reset", 32'({if0.M_TVALID, if0.RX_FIFO_RDEN}), 32'b01);
    step();
    checkOutput("t6 buffer empty", 32'(if0.M_TVALID), 32'h0);
    step();
    checkOutput("t6 resume", 32'({if0.M_TVALID, if0.M_TDATA}), 32'h199);

`ifdef UART_FIFO_HOST_STATS_EN
    // Stall counter saturation, then TX byte counter wrap
    applyStimulus(1'b1, 8'hEE, 1'b1);
    repeat (1030) step();
    checkOutput("stall saturate", 32'(if0.TX_STALL), 32'd1023);
    checkOutput("stall no writes", 32'(if0.TX_COUNT), 32'd0);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    repeat (65535) step();
    checkOutput("tx count max", 32'(if0.TX_COUNT), 32'hFFFF);
    step();
    checkOutput("tx count wrap", 32'(if0.TX_COUNT), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_host.md
Name: uart_fifo_host

Overview:
- Host-side end of the UART dual-clock FIFO pair, in the system-clock domain.
- RX path: reads bytes that the UART receiver pushed into the RX FIFO and presents them as a valid/ready byte stream with idle-gap framing (M_TLAST).
- TX path: accepts a valid/ready byte stream and pushes it into the TX FIFO feeding the UART transmitter.
- Counts TX bytes refused for FIFO-full conditions only when the stats feature is on.

Parameters:
- IDLE_CYCLES, 64, RX-empty gap in cycles that closes a frame; 0 disables framing.
- IDLE_BITS, 8, timer width; must satisfy IDLE_CYCLES < 2**IDLE_BITS.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-high reset
- RX_FIFO_RDEN  output  1  pop RX FIFO; data valid on RX_FIFO_DIN next cycle
- RX_FIFO_EMPTY  input  1  RX FIFO empty
- RX_FIFO_DIN  input  8  RX FIFO read data
- M_TDATA  output  8  RX stream byte
- M_TVALID  output  1  RX stream valid
- M_TLAST  output  1  byte is last before an idle gap
- M_TREADY  input  1  RX stream sink ready
- S_TDATA  input  8  TX stream byte
- S_TVALID  input  1  TX stream valid
- S_TREADY  output  1  TX stream ready (= !TX_FIFO_FULL)
- TX_FIFO_WREN  output  1  push TX FIFO
- TX_FIFO_FULL  input  1  TX FIFO full
- TX_FIFO_DOUT  output  8  TX FIFO write data (= S_TDATA)

Behaviour:
- Reset (async assert, sync deassert by the integrator): buffer emptied, in-flight flag, timer and hold flag cleared. M_TVALID=0, M_TLAST=0, M_TDATA=0, RX_FIFO_RDEN=0. TX outputs are combinational.
- RX buffer:
  - 2-entry FIFO (head, tail) with count 0..2 and an in-flight flag.
  - RX_FIFO_RDEN = !RX_FIFO_EMPTY & (count + inflight < 2).
  - inflight <= RDEN. A byte is written into the buffer the cycle after RDEN.
  - Throughput of at least 1 byte per 2 cycles.
- Presentation when IDLE_CYCLES=0:
  - M_TVALID = count>0, M_TLAST=0.
  - Read-to-M_TVALID latency is 2 cycles.
- Presentation when IDLE_CYCLES>0:
  - Head is presented with TLAST=0 when count==2.
  - Head is presented with TLAST=1 when count==1, !inflight and timer==IDLE_CYCLES.
- Timer:
  - Increments each cycle that count==1 & !inflight & RX_FIFO_EMPTY.
  - Saturates at IDLE_CYCLES.
  - Clears on any other cycle and on pop.
- Stability (hold flag):
  - Once M_TVALID rises, M_TVALID, M_TDATA and M_TLAST hold until M_TVALID&M_TREADY.
  - A byte arriving after TLAST=1 was presented does not retract or alter it. The hold flag latches TLAST.
- Pop and simultaneous events:
  - Pop on M_TVALID&M_TREADY: head<=tail, count--.
  - Simultaneous pop and arrival: count unchanged, new byte goes to the correct slot.
- TX path:
  - TX_FIFO_WREN = S_TVALID & !TX_FIFO_FULL, TX_FIFO_DOUT = S_TDATA.
  - No bytes dropped: backpressure via S_TREADY.
- Reset mid-frame: buffered and in-flight bytes are discarded. The RX FIFO is not flushed.

Optional Feature:
- UART_FIFO_HOST_STATS_EN defined:
  - Adds outputs RX_COUNT[15:0] and TX_COUNT[15:0].
  - RX_COUNT increments on each M_TVALID&M_TREADY.
  - TX_COUNT increments on each TX_FIFO_WREN.
  - Both wrap at 0xFFFF->0 and reset to 0.
  - Adds output TX_STALL[9:0], which increments on S_TVALID&TX_FIFO_FULL cycles and saturates at 1023.
- Undefined: these ports and registers are absent.

Decomposition:
- Package uart_fifo_pkg holds:
  - typedef byte_t (logic [7:0]);
  - localparam RXBUF_DEPTH=2;
  - the stat counter widths.
- One sub-module, uart_fifo_host_rxbuf: 2-entry buffer with count/inflight and pop/push.
- Timer, framing and hold logic stay in the top.

Test Plan:
- IDLE_CYCLES=0; RX FIFO holds 0x11,0x22,0x33; M_TREADY=1 -> M_TDATA 0x11,0x22,0x33 in order, TLAST always 0, exactly 3 RDEN pulses.
- IDLE_CYCLES=4; single byte 0xA5 then FIFO empty -> M_TVALID rises with TLAST=1 after 4 empty cycles. No TLAST before that.
- IDLE_CYCLES=4; bytes 0x01,0x02 back-to-back then empty -> 0x01 presented TLAST=0, 0x02 presented TLAST=1 after the gap.
- M_TREADY=0 for 10 cycles with TLAST=1 byte 0x5A presented while a new byte 0x6B arrives -> 0x5A/TLAST=1 held stable, then 0x6B follows. RDEN stops once count+inflight==2.
- TX: S_TVALID=1 with 0x10..0x14, TX_FIFO_FULL high for cycles 2-3 -> S_TREADY low and WREN low those cycles, all 5 bytes written in order.
- RESET pulsed mid-frame with 2 bytes buffered -> M_TVALID=0 immediately, RDEN=0, buffer empty. STATS_EN build: RX_COUNT/TX_COUNT = 0, wrap verified at 0xFFFF.
